// File: rtl/data_mem_pkg.sv
// Shared types and constants for the handshaked, byte-enabled data memory.
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int unsigned MAX_WAIT_STATES = 7;
  localparam int unsigned WCNT_W          = 3;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_array_be.sv
// Single-port DEPTH x DATA_W storage with per-byte write enables and a
// registered read port; all sequencing is done by the caller.
module mem_array_be
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  localparam int unsigned LANES = lane_count(DATA_W),
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [LANES-1:0]  i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane write: lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register holds the last read word until another read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= {DATA_W{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked data memory: clears itself after reset, then serves one
// read or byte-enabled write at a time with WAIT_STATES extra cycles each.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_STATES = 1,
  localparam int unsigned LANES      = lane_count(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LANES-1:0]  byte_en,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              done
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_STATES);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1'b1);
  localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};

  if (((DATA_W % 8) != 0) || (DATA_W == 0)) begin : g_bad_data_w
    $error("data_mem_ctrl: DATA_W must be a non-zero multiple of 8");
  end
  if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("data_mem_ctrl: WAIT_STATES must be in 0..7");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic [LANES-1:0]  r_be_q;
  logic              r_op_wr_q;
  logic              r_ready;
  logic              r_done;
  logic              w_ready_nxt;
  logic              w_done_nxt;
  logic              w_accept;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [LANES-1:0]  w_mem_be;
  logic [DATA_W-1:0] w_rdata;

  // State, counters, request latches and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= {ADDR_W{1'b0}};
      r_wcnt    <= WCNT_ZERO;
      r_addr_q  <= {ADDR_W{1'b0}};
      r_wdata_q <= {DATA_W{1'b0}};
      r_be_q    <= {LANES{1'b0}};
      r_op_wr_q <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
      if (w_accept) begin
        r_addr_q  <= addr;
        r_wdata_q <= data_in;
        r_be_q    <= byte_en;
        r_op_wr_q <= MemWrite;
      end
    end
  end

  // Next state, counter updates and memory port steering.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_wcnt_nxt    = r_wcnt;
    w_accept      = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_re      = 1'b0;
    w_mem_addr    = r_addr_q;
    w_mem_wdata   = r_wdata_q;
    w_mem_be      = r_be_q;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_addr    = r_clr_ptr;
        w_mem_wdata   = {DATA_W{1'b0}};
        w_mem_be      = {LANES{1'b1}};
        w_clr_ptr_nxt = r_clr_ptr + ADDR_ONE;
        if (r_clr_ptr == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        // A combined read+write request is latched as a write only.
        if (MemRead || MemWrite) begin
          w_accept    = 1'b1;
          w_wcnt_nxt  = WCNT_INIT;
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_wcnt != WCNT_ZERO) begin
          w_wcnt_nxt = r_wcnt - WCNT_ONE;
        end else begin
          w_mem_we    = r_op_wr_q;
          w_mem_re    = ~r_op_wr_q;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_RESP);
  end

  // Reset wins over any access in flight, so no partial write can land.
  mem_array_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (w_mem_addr),
    .i_we    (w_mem_we & ~rst),
    .i_re    (w_mem_re & ~rst),
    .i_be    (w_mem_be),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_rdata)
  );

  assign data_out = w_rdata;
  assign ready    = r_ready;
  assign done     = r_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances cover the default
// configuration, a 3-wait-state variant and a 32-bit/64-word/0-wait variant.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic [2:0]  mwr_v;
  logic [2:0]  mrd_v;
  logic [5:0]  addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [3:0]  be_v    [3];
  logic [15:0] dout0;
  logic [15:0] dout1;
  logic [31:0] dout2;
  logic [2:0]  rdy_v;
  logic [2:0]  dn_v;

  typedef struct {
    int          lat;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .addr(addr_v[0][3:0]), .data_in(wdata_v[0][15:0]),
    .byte_en(be_v[0][1:0]), .MemWrite(mwr_v[0]), .MemRead(mrd_v[0]),
    .data_out(dout0), .ready(rdy_v[0]), .done(dn_v[0])
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst_v[1]), .addr(addr_v[1][3:0]), .data_in(wdata_v[1][15:0]),
    .byte_en(be_v[1][1:0]), .MemWrite(mwr_v[1]), .MemRead(mrd_v[1]),
    .data_out(dout1), .ready(rdy_v[1]), .done(dn_v[1])
  );

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(6), .WAIT_STATES(0)) u2 (
    .clk(clk), .rst(rst_v[2]), .addr(addr_v[2]), .data_in(wdata_v[2]),
    .byte_en(be_v[2]), .MemWrite(mwr_v[2]), .MemRead(mrd_v[2]),
    .data_out(dout2), .ready(rdy_v[2]), .done(dn_v[2])
  );

  function automatic logic [31:0] dout_of(input int d);
    case (d)
      0:       return {16'h0000, dout0};
      1:       return {16'h0000, dout1};
      default: return dout2;
    endcase
  endfunction

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse reset for one edge, then measure the clear sweep until ready rises.
  task automatic reset_sweep(input int d, input int depth, input string tag);
    int   n;
    logic saw_done;
    @(negedge clk);
    rst_v[d] = 1'b1;
    mwr_v[d] = 1'b0;
    mrd_v[d] = 1'b0;
    @(negedge clk);
    rst_v[d] = 1'b0;
    chk({tag, ".rst_data_out"}, dout_of(d), 32'h0);
    chk({tag, ".rst_done"}, 32'(dn_v[d]), 32'h0);
    n = 0;
    saw_done = 1'b0;
    while (rdy_v[d] !== 1'b1 && n < 200) begin
      saw_done = saw_done | dn_v[d];
      n++;
      @(negedge clk);
    end
    chk({tag, ".sweep_len"}, 32'(n), 32'(depth));
    chk({tag, ".sweep_no_done"}, 32'(saw_done), 32'h0);
  endtask

  // Issue one request; the expected latency and data_out are queued at
  // issue time and retired when done is seen.
  task automatic access(input int d, input logic wr, input logic rd, input logic [5:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] rd_exp, input string tag);
    exp_t        e;
    exp_t        got_e;
    int          n;
    logic [31:0] held;
    n = 0;
    while (rdy_v[d] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready"}, 32'(rdy_v[d]), 32'h1);
    held   = dout_of(d);
    e.lat  = 2 + ws_of(d);
    e.data = (rd && !wr) ? rd_exp : held;
    sb.push_back(e);
    addr_v[d]  = a;
    wdata_v[d] = wd;
    be_v[d]    = b;
    mwr_v[d]   = wr;
    mrd_v[d]   = rd;
    @(negedge clk);
    mwr_v[d] = 1'b0;
    mrd_v[d] = 1'b0;
    n = 1;
    while (dn_v[d] !== 1'b1 && n < 40) begin
      chk({tag, ".busy_ready"}, 32'(rdy_v[d]), 32'h0);
      chk({tag, ".busy_hold"}, dout_of(d), held);
      @(negedge clk);
      n++;
    end
    got_e = sb.pop_front();
    chk({tag, ".latency"}, 32'(n), 32'(got_e.lat));
    chk({tag, ".data_out"}, dout_of(d), got_e.data);
    chk({tag, ".resp_ready"}, 32'(rdy_v[d]), 32'h0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(dn_v[d]), 32'h0);
    chk({tag, ".ready_back"}, 32'(rdy_v[d]), 32'h1);
  endtask

  initial begin
    rst_v = 3'b111;
    mwr_v = 3'b000;
    mrd_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_v[i]  = 6'd0;
      wdata_v[i] = 32'h0;
      be_v[i]    = 4'h0;
    end

    // Default instance: sweep, preload garbage, sweep again, check clear.
    reset_sweep(0, 16, "u0.sweep0");
    access(0, 1'b1, 1'b0, 6'd0,  32'h0000DEAD, 4'h3, 32'h0, "u0.junk0");
    access(0, 1'b1, 1'b0, 6'd7,  32'h0000BEEF, 4'h3, 32'h0, "u0.junk7");
    access(0, 1'b1, 1'b0, 6'd15, 32'h0000C0DE, 4'h3, 32'h0, "u0.junk15");
    access(0, 1'b0, 1'b1, 6'd7,  32'h0, 4'h0, 32'h0000BEEF, "u0.junk7_rd");
    reset_sweep(0, 16, "u0.sweep1");
    access(0, 1'b0, 1'b1, 6'd0,  32'h0, 4'h0, 32'h0, "u0.clr0");
    access(0, 1'b0, 1'b1, 6'd7,  32'h0, 4'h0, 32'h0, "u0.clr7");
    access(0, 1'b0, 1'b1, 6'd15, 32'h0, 4'h0, 32'h0, "u0.clr15");

    access(0, 1'b1, 1'b0, 6'd5, 32'h00001234, 4'h3, 32'h0, "u0.wr5");
    access(0, 1'b0, 1'b1, 6'd5, 32'h0, 4'h0, 32'h00001234, "u0.rd5");

    access(0, 1'b1, 1'b0, 6'd3, 32'h0000AAAA, 4'h3, 32'h0, "u0.be11");
    access(0, 1'b1, 1'b0, 6'd3, 32'h00005555, 4'h1, 32'h0, "u0.be01");
    access(0, 1'b1, 1'b0, 6'd3, 32'h0000FFFF, 4'h0, 32'h0, "u0.be00");
    access(0, 1'b0, 1'b1, 6'd3, 32'h0, 4'h0, 32'h0000AA55, "u0.be_rd");

    access(0, 1'b1, 1'b0, 6'd11, 32'h0000000C, 4'h3, 32'h0, "u0.wr11");
    access(0, 1'b0, 1'b1, 6'd11, 32'h0, 4'h0, 32'h0000000C, "u0.rd11");
    access(0, 1'b1, 1'b1, 6'd11, 32'h0000BEEF, 4'h3, 32'h0, "u0.both11");
    access(0, 1'b0, 1'b1, 6'd11, 32'h0, 4'h0, 32'h0000BEEF, "u0.rd11_new");

    // Three wait states: latency check, then reset while an access is busy.
    reset_sweep(1, 16, "u1.sweep0");
    access(1, 1'b1, 1'b0, 6'd9, 32'h00004321, 4'h3, 32'h0, "u1.wr9");
    access(1, 1'b0, 1'b1, 6'd9, 32'h0, 4'h0, 32'h00004321, "u1.rd9");
    @(negedge clk);
    chk("u1.pre_abort_ready", 32'(rdy_v[1]), 32'h1);
    addr_v[1]  = 6'd2;
    wdata_v[1] = 32'h00007777;
    be_v[1]    = 4'h3;
    mwr_v[1]   = 1'b1;
    reset_sweep(1, 16, "u1.abort");
    access(1, 1'b0, 1'b1, 6'd2, 32'h0, 4'h0, 32'h0, "u1.rd2");

    // Wide, deep, zero-wait corner.
    reset_sweep(2, 64, "u2.sweep0");
    access(2, 1'b0, 1'b1, 6'd40, 32'h0, 4'h0, 32'h0, "u2.clr40");
    access(2, 1'b1, 1'b0, 6'd40, 32'hDEADBEEF, 4'hA, 32'h0, "u2.wr40");
    access(2, 1'b0, 1'b1, 6'd40, 32'h0, 4'h0, 32'hDE00BE00, "u2.rd40");
    access(2, 1'b1, 1'b0, 6'd63, 32'h01020304, 4'hF, 32'h0, "u2.wr63");
    access(2, 1'b0, 1'b1, 6'd63, 32'h0, 4'h0, 32'h01020304, "u2.rd63");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the lab 4 datapath; successor to the fixed 16x16 data memory. It provides DATA_W-bit words at 2^ADDR_W addresses, per-byte write enables, a configurable number of wait states, and a hardware clear sweep after reset. It sits between the control unit (MemRead/MemWrite) and the ALU/register-file write-back mux. The control FSM stalls on `ready` and advances on `done`.

## Interface
- `DATA_W`, default 16: word width; must be a multiple of 8.
- `ADDR_W`, default 4: address width; DEPTH = 2^ADDR_W.
- `WAIT_STATES`, default 1: extra cycles per access; legal range 0..7.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `addr`  in  ADDR_W  word address.
- `data_in`  in  DATA_W  write data.
- `byte_en`  in  DATA_W/8  write lane mask; bit i covers data_in[8i+7:8i].
- `MemWrite`  in  1  write request.
- `MemRead`  in  1  read request.
- `data_out`  out  DATA_W  last read data; held until the next read completes.
- `ready`  out  1  request can be accepted this cycle.
- `done`  out  1  one-cycle pulse when an access completes.

## Operation
- States:
  - CLEAR: writes 0 to mem[clr_ptr] each cycle, then increments clr_ptr.
  - IDLE: `ready`=1.
  - BUSY: counts down wait states.
  - RESP: `done`=1.
- rst=1 at an edge:
  - state<=CLEAR, clr_ptr<=0.
  - data_out<=0, ready<=0, done<=0.
  - Any pending access is abandoned; no partial write occurs.
- CLEAR -> IDLE on the edge that clears address DEPTH-1. The sweep takes exactly DEPTH cycles. Requests during CLEAR are ignored, not queued.
- IDLE, (MemRead|MemWrite)=1 at an edge:
  - Latches addr, data_in, byte_en and op.
  - wcnt<=WAIT_STATES; state -> BUSY.
- Both MemRead and MemWrite high: treated as a write only; data_out unchanged.
- BUSY:
  - If wcnt!=0: wcnt decrements.
  - If wcnt==0: the access is performed on that edge and state -> RESP.
    - Write: lanes with byte_en=1 are updated; other lanes are unchanged.
    - Read: data_out<=mem[addr_q].
- RESP -> IDLE unconditionally on the next edge.
- Write with byte_en=0: memory unchanged, but `done` still pulses.
- Read-after-write to the same address returns the new data, since the write completes before the read is accepted.
- Inputs are don't-care outside IDLE.

## Timing
- Request is accepted at edge E0. `done` is high during the cycle after edge E0+1+WAIT_STATES. Access latency is 1+WAIT_STATES cycles.
- data_out is valid in the same cycle `done` is high.
- Throughput is one access per 3+WAIT_STATES cycles. `ready` is low in BUSY and RESP and high again in the cycle after `done`.
- After rst is released, `ready` first rises DEPTH cycles after the first edge with rst=0.

## Structure
- Package `data_mem_pkg`:
  - State enum {CLEAR, IDLE, BUSY, RESP}.
  - localparam function for the lane count DATA_W/8.
  - Max WAIT_STATES constant (7) and wcnt width (3).
- Sub-module `mem_array_be`:
  - Single-port DEPTH x DATA_W storage.
  - Synchronous byte-enabled write and a synchronous read register.
  - Contains no control logic.
- The FSM, latch registers, wait counter and clear pointer live in `data_mem_ctrl`.
- Elaboration check: DATA_W%8==0 and WAIT_STATES<=7.

## Test plan
- Reset sweep (defaults):
  - Stimulus: preload garbage, assert rst 1 cycle, release.
  - Required: ready=0 for exactly 16 cycles, then 1; reads of addresses 0, 7 and 15 all return 0x0000.
- Write/read latency (WAIT_STATES=1):
  - Stimulus: write 0x1234 to address 5, then read address 5.
  - Required: done pulses 2 cycles after each accept; data_out=0x1234 in the read's done cycle; ready low for 3 cycles per access.
- Byte enables:
  - Stimulus: write 0xAAAA to address 3 with byte_en=2'b11, then 0x5555 with 2'b01, then 0xFFFF with 2'b00; read address 3.
  - Required: data_out=0xAA55; done pulses for all three writes.
- Simultaneous requests:
  - Stimulus: read address 11 (value 0x000C), then issue MemRead=MemWrite=1 at address 11 with 0xBEEF.
  - Required: data_out stays 0x000C during the write; a subsequent read returns 0xBEEF.
- Reset mid-access:
  - Stimulus: WAIT_STATES=3, write 0x7777 to address 2, assert rst during BUSY.
  - Required: done never pulses; after the sweep, address 2 reads 0x0000.
- Parameter corner (DATA_W=32, ADDR_W=6, WAIT_STATES=0):
  - Required: sweep takes 64 cycles; latency is 1 cycle; write 0xDEADBEEF with byte_en=4'b1010 to a cleared address reads back 0xDE00BE00.
